// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - signed product to sign + packed BCD via sequential double-dabble
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      product,
  output logic                  busy,
  output logic                  out_valid,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [BW-1:0]     work;
  logic [BW-1:0]     work_adj;
  logic [WIDTH-1:0]  mag;
  logic [CW-1:0]     cnt;
  logic              neg;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  assign busy      = (state == CONVERT);
  assign out_valid = (state == DONE);

  // The captured sign is held in neg and published with bcd so the display
  // never shows a new sign next to an old magnitude.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      mag   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      sign  <= 1'b0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg   <= product[WIDTH-1];
            mag   <= product[WIDTH-1] ? (WIDTH'(0) - product) : product;
            work  <= '0;
            cnt   <= '0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          {work, mag} <= {work_adj[BW-2:0], mag, 1'b0};
          cnt         <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bcd   <= {work_adj[BW-2:0], mag[WIDTH-1]};
            sign  <= neg;
            state <= DONE;
          end
        end
        DONE: begin
          if (!in_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - randomized self-checking bench with behavioural BCD model
module tb_product_bcd_converter;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic [WIDTH-1:0]     product = '0;
  logic                 busy;
  logic                 out_valid;
  logic                 sign;
  logic [4*DIGITS-1:0]  bcd;

  int errors = 0;
  int checks = 0;

  product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .product(product),
    .busy(busy), .out_valid(out_valid), .sign(sign), .bcd(bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of a magnitude, computed arithmetically.
  function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: phase 0 idle, 1 converting, 2 result presented.
  int                  m_phase = 0;
  int                  m_left = 0;
  logic                m_sign = 1'b0;
  logic [4*DIGITS-1:0] m_bcd = '0;
  logic                cap_sign;
  logic [4*DIGITS-1:0] cap_bcd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_left = 0; m_sign = 1'b0; m_bcd = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          longint v;
          v = longint'($signed(product));
          cap_sign = (v < 0);
          cap_bcd  = to_bcd(v < 0 ? -v : v);
          m_left   = WIDTH;
          m_phase  = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; m_sign = cap_sign; m_bcd = cap_bcd;
          end
        end
        default: if (!in_valid) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("bcd", 32'(bcd), 32'(m_bcd));
      if (m_phase != 1) chk("sign", 32'(sign), 32'(m_sign));
      if (busy && out_valid) chk("busy_and_valid", 32'(1), 32'(0));
    end
  end

  // Start a conversion at a negedge and count edges until out_valid is seen.
  task automatic convert(input logic [WIDTH-1:0] p, input bit pulse, output int edges);
    product  = p;
    in_valid = 1'b1;
    edges    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin edges = k; break; end
      if (pulse && k == 1) in_valid = 1'b0;
      if (pulse && k == 3) product = 16'd1;
    end
    if (edges == 0) chk("timeout", 32'(0), 32'(1));
  endtask

  task automatic release_valid();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  int e;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_valid", 32'(out_valid), 32'(0));
    chk("reset_bcd", 32'(bcd), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    convert(16'hFF7C, 1'b0, e);
    chk("t1_lat", 32'(e), 32'(17));
    chk("t1_sign", 32'(sign), 32'(1));
    chk("t1_bcd", 32'(bcd), 32'h00132);
    repeat (20) @(negedge clk);
    chk("t1_held", 32'(out_valid), 32'(1));
    release_valid();

    convert(16'h4000, 1'b0, e);
    chk("t2_bcd", 32'(bcd), 32'h16384);
    chk("t2_sign", 32'(sign), 32'(0));
    release_valid();
    convert(16'h0000, 1'b0, e);
    chk("t2_zero_bcd", 32'(bcd), 32'h00000);
    chk("t2_zero_sign", 32'(sign), 32'(0));
    release_valid();

    convert(16'h8000, 1'b0, e);
    chk("t3_bcd", 32'(bcd), 32'h32768);
    chk("t3_sign", 32'(sign), 32'(1));
    release_valid();

    convert(16'd9999, 1'b1, e);
    chk("t4_bcd", 32'(bcd), 32'h09999);
    @(negedge clk);
    chk("t4_one_cycle", 32'(out_valid), 32'(0));
    chk("t4_held_bcd", 32'(bcd), 32'h09999);
    @(negedge clk);

    product  = 16'd4321;
    in_valid = 1'b1;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_valid", 32'(out_valid), 32'(0));
    chk("t5_bcd", 32'(bcd), 32'(0));
    chk("t5_sign", 32'(sign), 32'(0));
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    convert(16'hFFFF, 1'b0, e);
    chk("t5_sign2", 32'(sign), 32'(1));
    chk("t5_bcd2", 32'(bcd), 32'h00001);
    release_valid();

    convert(16'h3F01, 1'b0, e);
    chk("t6_lat_a", 32'(e), 32'(17));
    chk("t6_bcd_a", 32'(bcd), 32'h16129);
    in_valid = 1'b0;
    @(negedge clk);
    convert(16'hFFFF, 1'b0, e);
    chk("t6_lat_b", 32'(e), 32'(17));
    chk("t6_bcd_b", 32'(bcd), 32'h00001);
    chk("t6_sign_b", 32'(sign), 32'(1));
    release_valid();

    for (int n = 0; n < 60; n++) begin
      convert(WIDTH'($urandom), 1'($urandom_range(0, 1)), e);
      chk("rnd_lat", 32'(e), 32'(17));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
